multiport_regfile: RTL and testbench
====================================

// Module: multiport_regfile
// PURPOSE
//  Parametrised GPR file: NUM_RD combinational read ports, two write ports (WB0, WB1), a busy
//  scoreboard and a sequential clear engine. Sits between ID (reads, issue) and WB (writes).
//  Register 0 always reads zero.
// PARAMETERS
//  DATA_W  32  register width, bits
//  ADDR_W  5   address width; NREG = 2**ADDR_W registers
//  NUM_RD  2   number of read ports
// PORTS
//  clk        in   1              clock, all state updates on posedge
//  rst        in   1              synchronous, active-high reset
//  we0        in   1              write enable, port 0
//  waddr0     in   ADDR_W         write address, port 0
//  wdata0     in   DATA_W         write data, port 0
//  we1        in   1              write enable, port 1 (priority port)
//  waddr1     in   ADDR_W         write address, port 1
//  wdata1     in   DATA_W         write data, port 1
//  re         in   NUM_RD         per-port read enable
//  raddr      in   NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
//  rdata      out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
//  rd_busy    out  NUM_RD         read operand has an outstanding producer
//  alloc_en   in   1              issue: mark alloc_addr busy
//  alloc_addr in   ADDR_W         destination register being issued
//  clear_req  in   1              request full register clear (flush)
//  ready      out  1              1 = RUN state, file usable
// BEHAVIOUR
//  FSM: CLEAR, RUN. rst -> CLEAR, clr_idx=1, busy=0. In CLEAR, one register zeroed per cycle
//   (regs[clr_idx]<=0, clr_idx++). Cycle clr_idx==NREG-1 -> RUN next edge.
//   CLEAR lasts NREG-1 cycles. clear_req in RUN -> CLEAR, clr_idx=1, busy=0.
//   clear_req in CLEAR is ignored.
//  ready: registered, 0 in CLEAR and on reset, 1 in RUN.
//  In CLEAR: we0/we1/alloc_en ignored; rdata=0, rd_busy=0 for all ports.
//  rst mid-CLEAR or mid-RUN: restart CLEAR at idx 1; prior contents irrelevant.
//  Writes (RUN): regs[waddrN]<=wdataN at posedge if weN and waddrN!=0.
//   Both ports, same address: port 1 data wins. Different addresses: both written.
//  Reads (combinational, zero latency), per port k:
//   rdata_k = 0 if rst, !ready, !re[k] or raddr_k==0;
//   otherwise bypass value (see CONFIGURATION) or regs[raddr_k].
//  Scoreboard busy[NREG-1:1], busy[0] const 0:
//   a write (either port) to a clears its bit; alloc_en sets busy[alloc_addr].
//   Alloc and write same address, same cycle: set wins.
//   Alloc to address 0 ignored.
//   rd_busy[k] = re[k] & ready & busy[raddr_k], except when bypassed (below).
//  All arithmetic unsigned; clr_idx ADDR_W bits, no wrap beyond NREG-1.
// CONFIGURATION
//  RF_BYPASS_EN defined: in RUN, a read with raddr_k!=0 matching an enabled write address
//   returns that write's wdata in the same cycle (port 1 before port 0), and rd_busy[k]=0.
//  RF_BYPASS_EN undefined: reads return the stored value (write visible next cycle);
//   rd_busy reflects busy before this cycle's clear.
// TESTING
//  T1 rst 1 cycle -> ready=0 for 31 cycles (ADDR_W=5), then 1; every rdata=0 throughout.
//  T2 RUN, we0 waddr0=3 wdata0=0xA5A5A5A5, next cycle read r3 -> 0xA5A5A5A5;
//     write r0=0xFFFFFFFF -> r0 reads 0.
//  T3 we0 and we1 to r7, same cycle: 0x11 / 0x22 -> r7=0x22;
//     r8/r9 on separate ports -> both written.
//  T4 alloc r5 -> rd_busy=1 reading r5; we1 r5=0x55 -> BYPASS: same cycle rdata=0x55,
//     rd_busy=0; no BYPASS: old value, busy=1, then 0x55 and busy=0 next cycle.
//     Alloc and write r5 same cycle -> busy stays 1.
//  T5 clear_req after writing r1..r31 -> ready=0, writes ignored during CLEAR,
//     all reads 0 after return to RUN.
//  T6 rst asserted at CLEAR idx 10 -> CLEAR restarts, full 31 cycles before ready.

Source files
------------

// File: rtl/multiport_regfile.sv
// multiport_regfile
//   General-purpose register file between ID (reads, issue) and WB (writes).
//   NUM_RD combinational read ports, two write ports (port 1 has priority on
//   an address collision), a per-register busy scoreboard and a sequential
//   clear engine that zeroes one register per cycle after reset or a flush.
//   Register 0 always reads zero and is never busy.
//
//   Optional feature macro: RF_BYPASS_EN
//     defined   -> a read that matches an enabled write address in the same
//                  cycle returns that write's data (port 1 before port 0) and
//                  reports not-busy.
//     undefined -> reads return the stored value; a write becomes visible on
//                  the next cycle.
//
// Ports
//   clk, rst                     clock (posedge), synchronous active-high reset
//   we0/waddr0/wdata0            write port 0
//   we1/waddr1/wdata1            write port 1 (wins on same-address collision)
//   re[NUM_RD]                   per-port read enable
//   raddr[NUM_RD*ADDR_W]         read address, port k at [k*ADDR_W +: ADDR_W]
//   rdata[NUM_RD*DATA_W]         read data,    port k at [k*DATA_W +: DATA_W]
//   rd_busy[NUM_RD]              read operand still has an outstanding producer
//   alloc_en/alloc_addr          issue: mark destination register busy
//   clear_req                    flush request, full sequential clear
//   ready                        1 while the file is usable (RUN state)
module multiport_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     clear_req,
  output logic                     ready
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = {ADDR_W{1'b1}};

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   clr_idx;
  logic [NREG-1:0]     busy;
  logic [DATA_W-1:0]   regs [NREG];
  logic                run;
  logic                restart;

  assign run     = (state == RUN);
  assign restart = run && clear_req;

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_idx == LAST_IDX) state_next = RUN;
      RUN:     if (clear_req) state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  // clr_idx starts at 1 because register 0 has no storage to clear; it holds
  // at LAST_IDX rather than wrapping back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      ready   <= 1'b0;
      clr_idx <= FIRST_IDX;
    end else begin
      state <= state_next;
      ready <= (state_next == RUN);
      if (restart)
        clr_idx <= FIRST_IDX;
      else if (!run && clr_idx != LAST_IDX)
        clr_idx <= clr_idx + 1'b1;
    end
  end

  // Scoreboard: writes retire a producer, alloc claims one. Alloc is applied
  // last so it wins when both hit the same register in one cycle.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      busy <= '0;
    end else if (run) begin
      if (we0 && waddr0 != '0) busy[waddr0] <= 1'b0;
      if (we1 && waddr1 != '0) busy[waddr1] <= 1'b0;
      if (alloc_en && alloc_addr != '0) busy[alloc_addr] <= 1'b1;
    end
  end

  // Storage: clear engine in CLEAR, write ports in RUN. Port 1 is assigned
  // after port 0 so it wins on a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        regs[clr_idx] <= '0;
      end else begin
        if (we0 && waddr0 != '0) regs[waddr0] <= wdata0;
        if (we1 && waddr1 != '0) regs[waddr1] <= wdata1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : gen_rd
    logic [ADDR_W-1:0] ra;
    logic              rd_ok;

    assign ra    = raddr[k*ADDR_W +: ADDR_W];
    assign rd_ok = !rst && ready && re[k] && (ra != '0);

`ifdef RF_BYPASS_EN
    logic hit0;
    logic hit1;

    assign hit0 = we0 && (waddr0 == ra) && (ra != '0);
    assign hit1 = we1 && (waddr1 == ra) && (ra != '0);

    assign rdata[k*DATA_W +: DATA_W] = !rd_ok ? '0     :
                                       hit1   ? wdata1 :
                                       hit0   ? wdata0 : regs[ra];
    // A same-cycle write is forwarded, so the operand is no longer pending.
    assign rd_busy[k] = re[k] && ready && busy[ra] && !(hit0 || hit1);
`else
    assign rdata[k*DATA_W +: DATA_W] = rd_ok ? regs[ra] : '0;
    assign rd_busy[k] = re[k] && ready && busy[ra];
`endif
  end

endmodule

// File: tb/tb_multiport_regfile.sv
module tb_multiport_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     we0, we1;
  logic [ADDR_W-1:0]        waddr0, waddr1;
  logic [DATA_W-1:0]        wdata0, wdata1;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     alloc_en;
  logic [ADDR_W-1:0]        alloc_addr;
  logic                     clear_req;
  logic                     ready;

  int checks = 0;
  int errors = 0;

  multiport_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata), .rd_busy(rd_busy),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .clear_req(clear_req), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    re    = 2'b11;
    raddr = {a1, a0};
    #1;
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    alloc_en = 1'b0; alloc_addr = '0;
    clear_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    re = '0;
    raddr = '0;
    idle_inputs();

    // T1: reset then 31 clear cycles
    tick();
    rst = 1'b0;
    set_rd(5'd1, 5'd31);
    for (int i = 0; i < 31; i++) begin
      check($sformatf("t1_ready_c%0d", i), ready, 0);
      check($sformatf("t1_rdata_c%0d", i), rdata, 0);
      tick();
    end
    check("t1_ready_run", ready, 1);
    check("t1_rdata_run", rdata, 0);

    // T2: basic write / read, r0 hard-wired
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA5A5A5A5;
    set_rd(5'd3, 5'd0);
`ifdef RF_BYPASS_EN
    check("t2_same_cycle_r3", rdata[31:0], 32'hA5A5A5A5);
`else
    check("t2_same_cycle_r3", rdata[31:0], 32'h0);
`endif
    tick();
    idle_inputs();
    #1;
    check("t2_r3", rdata[31:0], 32'hA5A5A5A5);
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
    tick();
    idle_inputs();
    set_rd(5'd0, 5'd3);
    check("t2_r0_zero", rdata[31:0], 32'h0);
    check("t2_r3_port1", rdata[63:32], 32'hA5A5A5A5);
    re = 2'b10;
    #1;
    check("t2_re_gate", rdata[31:0], 32'h0);

    // T3: write-port collision and dual writes
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
    tick();
    we0 = 1'b1; waddr0 = 5'd8; wdata0 = 32'h88;
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h99;
    tick();
    idle_inputs();
    set_rd(5'd7, 5'd8);
    check("t3_r7_port1_wins", rdata[31:0], 32'h22);
    check("t3_r8", rdata[63:32], 32'h88);
    set_rd(5'd9, 5'd3);
    check("t3_r9", rdata[31:0], 32'h99);

    // T4: scoreboard
    alloc_en = 1'b1; alloc_addr = 5'd5;
    tick();
    idle_inputs();
    set_rd(5'd5, 5'd7);
    check("t4_busy_r5", rd_busy, 2'b01);
    check("t4_r5_old", rdata[31:0], 32'h0);
    re = 2'b10;
    #1;
    check("t4_busy_re_gate", rd_busy, 2'b00);
    re = 2'b11;
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h55;
    #1;
`ifdef RF_BYPASS_EN
    check("t4_wb_cycle_rdata", rdata[31:0], 32'h55);
    check("t4_wb_cycle_busy", rd_busy, 2'b00);
`else
    check("t4_wb_cycle_rdata", rdata[31:0], 32'h0);
    check("t4_wb_cycle_busy", rd_busy, 2'b01);
`endif
    tick();
    idle_inputs();
    #1;
    check("t4_after_wb_rdata", rdata[31:0], 32'h55);
    check("t4_after_wb_busy", rd_busy, 2'b00);
    alloc_en = 1'b1; alloc_addr = 5'd5;
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h66;
    tick();
    idle_inputs();
    #1;
    check("t4_alloc_wins_busy", rd_busy, 2'b01);
    check("t4_alloc_wins_data", rdata[31:0], 32'h66);
    alloc_en = 1'b1; alloc_addr = 5'd0;
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h77;
    tick();
    idle_inputs();
    set_rd(5'd5, 5'd0);
    check("t4_retire_busy", rd_busy, 2'b00);
    check("t4_retire_data", rdata[31:0], 32'h77);

    // T5: fill, flush, verify clear
    for (int i = 1; i < 32; i++) begin
      we0 = 1'b1; waddr0 = ADDR_W'(i); wdata0 = 32'h1000_0000 + i;
      tick();
    end
    idle_inputs();
    alloc_en = 1'b1; alloc_addr = 5'd4;
    tick();
    idle_inputs();
    set_rd(5'd31, 5'd4);
    check("t5_r31_filled", rdata[31:0], 32'h1000_001F);
    check("t5_r4_busy", rd_busy, 2'b10);
    clear_req = 1'b1;
    tick();
    for (int i = 0; i < 31; i++) begin
      clear_req = 1'b1;
      we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'hDEAD;
      we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'hBEEF;
      alloc_en = 1'b1; alloc_addr = 5'd6;
      #1;
      check($sformatf("t5_ready_c%0d", i), ready, 0);
      check($sformatf("t5_rd_c%0d", i), {rd_busy, rdata}, 0);
      tick();
    end
    idle_inputs();
    #1;
    check("t5_ready_run", ready, 1);
    for (int i = 1; i < 32; i++) begin
      set_rd(ADDR_W'(i), ADDR_W'(32 - i));
      check($sformatf("t5_cleared_r%0d", i), {rd_busy, rdata}, 0);
    end

    // T6: reset in the middle of a clear restarts it
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_rd(5'd1, 5'd2);
    for (int i = 0; i < 31; i++) begin
      check($sformatf("t6_ready_c%0d", i), ready, 0);
      tick();
    end
    check("t6_ready_run", ready, 1);
    check("t6_rdata_run", rdata, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
